// File: rtl/data_ram_responder_pkg.sv
// Shared encodings and default widths for the data RAM responder and the ALU store/load initiators.
package data_ram_responder_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      REQ_RD = 1'b0,
      REQ_WR = 1'b1
   } req_t;

   // A bus cycle is a request only with CE high and exactly one of RD/WR.
   function automatic logic is_request(input logic ce, input logic rd, input logic wr);
      return ce && (rd ^ wr);
   endfunction

endpackage

// File: rtl/data_ram_responder_array.sv
// Single-port synchronous data array: byte-masked write, registered read on read enable only.
module data_ram_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   be,
   output logic [DATA_W-1:0]     rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: no reset here -- a reset branch would turn the array into flops and block RAM inference.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_ram_responder.sv
// Wait-stated RAM responder on the core's CE/RD/WR bus; DATA_RAM_RESPONDER_BYTE_EN adds iRAM_BE write strobes.
module data_ram_responder
   import data_ram_responder_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                iRAM_CE,
   input  logic                iRAM_RD,
   input  logic                iRAM_WR,
   input  logic [ADDR_W-1:0]   iRAM_ADDR,
   input  logic [DATA_W-1:0]   iRAM_DATA,
`ifdef DATA_RAM_RESPONDER_BYTE_EN
   input  logic [DATA_W/8-1:0] iRAM_BE,
`endif
   output logic [DATA_W-1:0]   oRAM_DATA,
   output logic                oRAM_READY,
   output logic                oRAM_BUSY,
   output logic                oRAM_ERR
);

   localparam int         BE_W      = DATA_W / 8;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t              state;
   logic [3:0]          cnt;
   req_t                lat_type;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_data;
   logic [BE_W-1:0]     lat_be;
   logic                done;
   logic [DATA_W-1:0]   arr_rdata;
   logic [BE_W-1:0]     bus_be;

`ifdef DATA_RAM_RESPONDER_BYTE_EN
   assign bus_be = iRAM_BE;
`else
   assign bus_be = '1;
`endif

   // The array acts only in RESP, so a reset during WAIT can never leave a partial write behind.
   data_ram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (iCLK),
      .we    ((state == RESP) && (lat_type == REQ_WR)),
      .re    ((state == RESP) && (lat_type == REQ_RD)),
      .addr  (lat_addr),
      .wdata (lat_data),
      .be    (lat_be),
      .rdata (arr_rdata)
   );

   // NOTE: all state and outputs use <= so every read in this block sees pre-edge values.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_type   <= REQ_RD;
         lat_addr   <= '0;
         lat_data   <= '0;
         lat_be     <= '0;
         done       <= 1'b0;
         oRAM_DATA  <= '0;
         oRAM_READY <= 1'b0;
         oRAM_BUSY  <= 1'b0;
         oRAM_ERR   <= 1'b0;
      end else begin
         oRAM_READY <= 1'b0;
         oRAM_ERR   <= 1'b0;
         done       <= 1'b0;

         // Array read data lands one cycle after RESP and is published together with READY.
         if (done) begin
            oRAM_READY <= 1'b1;
            if (lat_type == REQ_RD) oRAM_DATA <= arr_rdata;
         end
         if (oRAM_READY) oRAM_BUSY <= 1'b0;

         case (state)
            IDLE: begin
               if (!oRAM_BUSY && is_request(iRAM_CE, iRAM_RD, iRAM_WR)) begin
                  lat_type  <= iRAM_WR ? REQ_WR : REQ_RD;
                  lat_addr  <= iRAM_ADDR;
                  lat_data  <= iRAM_DATA;
                  lat_be    <= bus_be;
                  cnt       <= WAIT_INIT;
                  oRAM_BUSY <= 1'b1;
                  state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
               end else if (!oRAM_BUSY && iRAM_CE && iRAM_RD && iRAM_WR) begin
                  oRAM_ERR <= 1'b1;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) state <= RESP;
            end
            RESP: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
